axi_pwm: RTL and testbench



---
 rtl/axi_pwm_pkg.sv | 9 +
 rtl/axi_pwm_core.sv | 36 +++
 rtl/axi_pwm.sv | 147 ++++++++++++++
 tb/tb_axi_pwm.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_pwm_pkg.sv
// axi_pwm_pkg: register offsets and AXI response codes shared by the PWM block
package axi_pwm_pkg;
  localparam logic [7:0] REG_PRESCALE  = 8'h00;
  localparam logic [7:0] REG_PERIOD    = 8'h04;
  localparam logic [7:0] REG_COUNT     = 8'h08;
  localparam logic [7:0] REG_POLARITY  = 8'h0C;
  localparam logic [7:0] REG_DUTY_BASE = 8'h10;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
endpackage

// File: rtl/axi_pwm_core.sv
// pwm_core: prescaler, shared period counter and per-channel compare with polarity
module pwm_core #(
  parameter int NUM_OUTPUTS = 4,
  parameter int DW = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DW-1:0]                   prescale,
  input  logic [DW-1:0]                   period,
  input  logic [NUM_OUTPUTS-1:0]          polarity,
  input  logic [NUM_OUTPUTS-1:0][DW-1:0]  duty,
  output logic [NUM_OUTPUTS-1:0]          pwm,
  output logic [DW-1:0]                   count
);
  logic [DW-1:0] psc;
  logic [NUM_OUTPUTS-1:0] pwm_d;
  logic tick;
  // >= rather than == so shrinking PRESCALE below psc cannot stall for 2^DW clocks
  assign tick = psc >= prescale;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      psc   <= '0;
      count <= '0;
      pwm   <= '0;
    end else begin
      psc <= tick ? '0 : psc + 1'b1;
      if (period == '0) count <= '0;
      else if (tick) count <= (count >= period - 1'b1) ? '0 : count + 1'b1;
      pwm <= pwm_d;
    end
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++)
      pwm_d[i] = ((count < duty[i]) && (period != '0)) ^ polarity[i];
  end
endmodule

// File: rtl/axi_pwm.sv
// axi_pwm: AXI4 single-beat slave with register file driving a multi-channel PWM core
module axi_pwm
  import axi_pwm_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 8,
  parameter int NUM_OUTPUTS    = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  output logic [NUM_OUTPUTS-1:0]      pwm,
  input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                  s_axi_awprot,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                  s_axi_arprot,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready
);
  localparam int DW = AXI_DATA_WIDTH;
  localparam int SW = AXI_DATA_WIDTH / 8;
  localparam int WW = AXI_ADDR_WIDTH - 2;
  localparam logic [WW-1:0] W_PRESCALE = WW'(REG_PRESCALE >> 2);
  localparam logic [WW-1:0] W_PERIOD   = WW'(REG_PERIOD >> 2);
  localparam logic [WW-1:0] W_COUNT    = WW'(REG_COUNT >> 2);
  localparam logic [WW-1:0] W_POLARITY = WW'(REG_POLARITY >> 2);
  localparam logic [WW-1:0] W_DUTY     = WW'(REG_DUTY_BASE >> 2);
  logic aw_held, w_held, aw_fire, w_fire, ar_fire, do_write;
  logic [AXI_ID_WIDTH-1:0] awid_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, wa;
  logic [DW-1:0] wdata_q, wd, rd;
  logic [SW-1:0] wstrb_q, ws;
  logic [WW-1:0] wi, ri;
  logic [DW-1:0] prescale, period, polarity, count;
  logic [NUM_OUTPUTS-1:0][DW-1:0] duty;
  logic unused;
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (s[b]) r[8*b+:8] = d[8*b+:8];
    return r;
  endfunction
  assign s_axi_awready = !aw_held && !s_axi_bvalid;
  assign s_axi_wready  = !w_held && !s_axi_bvalid;
  assign s_axi_arready = !s_axi_rvalid;
  assign s_axi_bresp   = RESP_OKAY;
  assign s_axi_rresp   = RESP_OKAY;
  assign aw_fire  = s_axi_awvalid && s_axi_awready;
  assign w_fire   = s_axi_wvalid && s_axi_wready;
  assign ar_fire  = s_axi_arvalid && s_axi_arready;
  // address and data may each come from the latch or from this cycle's handshake
  assign do_write = (aw_held || aw_fire) && (w_held || w_fire) && !s_axi_bvalid;
  assign wa = aw_held ? awaddr_q : s_axi_awaddr;
  assign wd = w_held ? wdata_q : s_axi_wdata;
  assign ws = w_held ? wstrb_q : s_axi_wstrb;
  assign wi = wa[AXI_ADDR_WIDTH-1:2];
  assign ri = s_axi_araddr[AXI_ADDR_WIDTH-1:2];
  assign unused = ^{s_axi_awprot, s_axi_arprot, wa[1:0], s_axi_araddr[1:0]};
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      awid_q       <= '0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bid    <= '0;
      s_axi_rvalid <= 1'b0;
      s_axi_rid    <= '0;
      s_axi_rdata  <= '0;
    end else begin
      if (aw_fire) begin
        aw_held  <= 1'b1;
        awid_q   <= s_axi_awid;
        awaddr_q <= s_axi_awaddr;
      end
      if (w_fire) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (do_write) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bid    <= aw_held ? awid_q : s_axi_awid;
      end
      if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
      end
      if (ar_fire) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rid    <= s_axi_arid;
        s_axi_rdata  <= rd;
      end else if (s_axi_rvalid && s_axi_rready) s_axi_rvalid <= 1'b0;
    end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      prescale <= '0;
      period   <= '0;
      polarity <= '0;
      duty     <= '0;
    end else if (do_write) begin
      if (wi == W_PRESCALE) prescale <= merge(prescale, wd, ws);
      if (wi == W_PERIOD) period <= merge(period, wd, ws);
      if (wi == W_POLARITY) polarity <= merge(polarity, wd, ws);
      for (int i = 0; i < NUM_OUTPUTS; i++)
        if (wi == W_DUTY + WW'(i)) duty[i] <= merge(duty[i], wd, ws);
    end
  always_comb begin
    rd = ri == W_PRESCALE ? prescale :
         ri == W_PERIOD   ? period   :
         ri == W_COUNT    ? count    :
         ri == W_POLARITY ? polarity : '0;
    for (int i = 0; i < NUM_OUTPUTS; i++)
      if (ri == W_DUTY + WW'(i)) rd = duty[i];
  end
  pwm_core #(.NUM_OUTPUTS(NUM_OUTPUTS), .DW(DW)) u_core (
    .clk      (aclk),
    .rst_n    (aresetn),
    .prescale (prescale),
    .period   (period),
    .polarity (polarity[NUM_OUTPUTS-1:0]),
    .duty     (duty),
    .pwm      (pwm),
    .count    (count)
  );
endmodule

// File: tb/tb_axi_pwm.sv
// tb_axi_pwm: table-driven register writes/read-backs with B/R scoreboards and PWM waveform checks
module tb_axi_pwm;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [3:0] pwm;
  logic [0:0] awid, bid, arid, rid;
  logic [7:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  always #5 aclk = ~aclk;
  axi_pwm dut (
    .aclk(aclk), .aresetn(aresetn), .pwm(pwm),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arprot(arprot),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata),
    .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );
  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          gap;
    logic [31:0] exp;
  } vec_t;
  typedef struct {
    logic [0:0]  id;
    logic [31:0] data;
    bit          rng;
  } rexp_t;
  vec_t vt[9];
  logic [0:0] bq[$];
  rexp_t rq[$];
  int pass_cnt = 0, total = 0, b_hs = 0, r_hs = 0, b_rise = 0, writes = 0;
  logic bv_prev = 1'b0;
  logic [0:0] next_rid = 1'b0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  always @(negedge aclk) begin
    if (bvalid && !bv_prev) b_rise++;
    bv_prev = bvalid;
    if (bvalid && bready) begin
      if (bq.size() == 0) begin
        total++;
        $display("FAIL unexpected_b: got bid 0x%0h expected no response", bid);
      end else check("bid", 32'(bid), 32'(bq.pop_front()));
      check("bresp", 32'(bresp), 32'd0);
      b_hs++;
    end
    if (rvalid && rready) begin
      if (rq.size() == 0) begin
        total++;
        $display("FAIL unexpected_r: got rdata 0x%0h expected no response", rdata);
      end else begin
        rexp_t e;
        e = rq.pop_front();
        check("rid", 32'(rid), 32'(e.id));
        if (e.rng) check("count_range", 32'(rdata <= e.data), 32'd1);
        else check("rdata", rdata, e.data);
      end
      check("rresp", 32'(rresp), 32'd0);
      r_hs++;
    end
  end
  // gap > 0: W follows AW by gap cycles; gap < 0: AW follows W; gap = 0: same cycle
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [0:0] id, input int gap);
    int cyc, n, n0;
    bit aw_done, w_done, aw_now, w_now;
    n0 = b_hs;
    cyc = 0;
    aw_done = 0;
    w_done = 0;
    bq.push_back(id);
    writes++;
    @(posedge aclk);
    #1;
    awaddr = a; awid = id; wdata = d; wstrb = s;
    if (gap >= 0) awvalid = 1'b1;
    if (gap <= 0) wvalid = 1'b1;
    while (!(aw_done && w_done) && cyc < 100) begin
      @(negedge aclk);
      aw_now = awvalid && awready;
      w_now = wvalid && wready;
      @(posedge aclk);
      #1;
      cyc++;
      if (aw_now) begin awvalid = 1'b0; aw_done = 1; end
      if (w_now) begin wvalid = 1'b0; w_done = 1; end
      if (gap > 0 && cyc == gap) wvalid = 1'b1;
      if (gap < 0 && cyc == -gap) awvalid = 1'b1;
    end
    n = 0;
    while (b_hs == n0 && n < 100) begin @(negedge aclk); n++; end
    check("b_handshake_seen", 32'(b_hs != n0), 32'd1);
  endtask
  task automatic axi_read(input logic [7:0] a, input logic [31:0] exp, input bit rng);
    int n, n0;
    n0 = r_hs;
    rq.push_back('{next_rid, exp, rng});
    @(posedge aclk);
    #1;
    araddr = a; arid = next_rid; arvalid = 1'b1;
    next_rid = ~next_rid;
    n = 0;
    do begin @(negedge aclk); n++; end while (!arready && n < 100);
    @(posedge aclk);
    #1;
    arvalid = 1'b0;
    n = 0;
    while (r_hs == n0 && n < 100) begin @(negedge aclk); n++; end
    check("r_handshake_seen", 32'(r_hs != n0), 32'd1);
  endtask
  task automatic apply(input int i);
    axi_write(vt[i].addr, vt[i].data, vt[i].strb, 1'(i), vt[i].gap);
    axi_read(vt[i].addr, vt[i].exp, 1'b0);
  endtask
  task automatic measure(input int ch, output int hi, output int lo);
    int n;
    n = 0;
    do begin @(negedge aclk); n++; end while (pwm[ch] && n < 4000);
    n = 0;
    do begin @(negedge aclk); n++; end while (!pwm[ch] && n < 4000);
    hi = 0;
    while (pwm[ch] && hi < 4000) begin hi++; @(negedge aclk); end
    lo = 0;
    while (!pwm[ch] && lo < 4000) begin lo++; @(negedge aclk); end
  endtask
  task automatic watch(input string name, input logic [3:0] mask, input logic [3:0] val, input int n);
    int bad;
    bad = 0;
    repeat (n) begin @(negedge aclk); if ((pwm & mask) != val) bad++; end
    check(name, 32'(bad), 32'd0);
  endtask
  initial begin
    repeat (100000) @(posedge aclk);
    $display("FAIL watchdog: got no finish expected finish within 100000 cycles");
    $fatal(1);
  end
  initial begin
    int hi, lo, n, n0;
    logic [7:0] reg_addr[9];
    logic [31:0] final_exp[9];
    reg_addr  = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h40};
    final_exp = '{32'd1, 32'd500, 32'd0, 32'd1, 32'd100, 32'h0000_FFFF, 32'd0, 32'd0, 32'd0};
    vt[0] = '{8'h00, 32'd0, 4'hF, 2, 32'd0};
    vt[1] = '{8'h04, 32'd500, 4'hF, 2, 32'd500};
    vt[2] = '{8'h10, 32'd250, 4'hF, 2, 32'd250};
    vt[3] = '{8'h14, 32'hFFFF_FFFF, 4'h3, 0, 32'h0000_FFFF};
    vt[4] = '{8'h00, 32'd1, 4'hF, 1, 32'd1};
    vt[5] = '{8'h0C, 32'd1, 4'hF, 3, 32'd1};
    vt[6] = '{8'h10, 32'd100, 4'hF, -2, 32'd100};
    vt[7] = '{8'h40, 32'hDEAD_BEEF, 4'hF, 0, 32'd0};
    vt[8] = '{8'h0C, 32'hFF, 4'h0, -1, 32'd1};
    awid = 0; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    arid = 0; araddr = 0; arprot = 0; arvalid = 0; bready = 1'b1; rready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_ready", 32'({awready, wready, arready}), 32'h7);
    check("rst_valid", 32'({bvalid, rvalid}), 32'd0);
    aresetn = 1'b1;
    for (int i = 0; i < 9; i++) axi_read(reg_addr[i], 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) apply(i);
    measure(0, hi, lo);
    check("pwm0_high", 32'(hi), 32'd250);
    check("pwm0_low", 32'(lo), 32'd250);
    watch("pwm31_low", 4'b1110, 4'b0000, 500);
    apply(3);
    watch("pwm1_const_high", 4'b1110, 4'b0010, 600);
    apply(4);
    measure(0, hi, lo);
    check("psc1_high", 32'(hi), 32'd500);
    check("psc1_low", 32'(lo), 32'd500);
    axi_read(8'h08, 32'd499, 1'b1);
    for (int i = 5; i < 7; i++) apply(i);
    measure(0, hi, lo);
    check("pol_high", 32'(hi), 32'd800);
    check("pol_low", 32'(lo), 32'd200);
    for (int i = 7; i < 9; i++) apply(i);
    check("b_rise_per_write", 32'(b_rise), 32'(writes));
    for (int i = 0; i < 9; i++) if (i != 2) axi_read(reg_addr[i], final_exp[i], 1'b0);
    bready = 1'b0;
    @(posedge aclk);
    #1;
    awaddr = 8'h18; awid = 1'b1; wdata = 32'd5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge aclk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("b_pending", 32'({bvalid, awready}), 32'h2);
    n = 0;
    while (!pwm[0] && n < 3000) begin @(negedge aclk); n++; end
    check("pwm0_mid_pulse", 32'(pwm[0]), 32'd1);
    @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm), 32'd0);
    check("async_rst_bvalid", 32'({bvalid, rvalid}), 32'd0);
    check("async_rst_ready", 32'({awready, wready, arready}), 32'h7);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    bready = 1'b1;
    n0 = b_hs;
    for (int i = 0; i < 9; i++) axi_read(reg_addr[i], 32'd0, 1'b0);
    check("no_b_after_reset", 32'(b_hs - n0), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
